// File: rtl/fb_pixel_writer.sv
// rtl/fb_pixel_writer.sv - pixel write FIFO, x/y to address conversion and frame clear (optional FBW_VBLANK_ONLY_EN)
module fb_pixel_writer #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int ADDR_W = 19,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [8:0]        req_y,
  input  logic [DATA_W-1:0] req_color,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_color,
  input  logic              vblank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              clr_done,
  output logic [7:0]        drop_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam int FULL_W = (ADDR_W > 20) ? ADDR_W : 20;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  logic [1:0]        state;
  logic              rst_done;
  logic              clr_pending;
  logic [DATA_W-1:0] clr_fill;
  logic [ADDR_W-1:0] clr_addr;

  logic [ADDR_W-1:0] fifo_addr [4];
  logic [DATA_W-1:0] fifo_data [4];
  logic [1:0]        wr_ptr, rd_ptr;
  logic [2:0]        count;

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic              en, fifo_full, fifo_empty, in_range;
  logic              req_fire, push, pop, clr_accept;
  logic [FULL_W-1:0] full_addr;

`ifdef FBW_VBLANK_ONLY_EN
  assign en = vblank;
`else
  // vblank is irrelevant here; every cycle may pop or clear
  assign en = vblank | 1'b1;
`endif

  assign full_addr  = FULL_W'(req_y) * FULL_W'(H_RES) + FULL_W'(req_x);
  assign in_range   = (int'(req_x) < H_RES) && (int'(req_y) < V_RES);
  assign fifo_full  = (count == 3'd4);
  assign fifo_empty = (count == 3'd0);
  // rst_done keeps ready low until the first edge after reset release
  assign req_ready  = rst_done && !fifo_full && (state == S_IDLE) && !clr_pending;
  assign req_fire   = req_valid && req_ready;
  assign push       = req_fire && in_range;
  assign pop        = en && !fifo_empty && ((state == S_IDLE) || (state == S_DRAIN));
  assign clr_accept = clr_start && rst_done && (state == S_IDLE) && !clr_pending;
  assign busy       = !fifo_empty || pend_valid || wr_en || (state != S_IDLE);

  // FIFO storage: addresses are computed once on entry
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= full_addr[ADDR_W-1:0];
      fifo_data[wr_ptr] <= req_color;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // Control FSM, pending stage, output write register and drop counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rst_done    <= 1'b0;
      clr_pending <= 1'b0;
      clr_fill    <= '0;
      clr_addr    <= '0;
      pend_valid  <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      clr_done    <= 1'b0;
      drop_cnt    <= 8'd0;
    end else begin
      rst_done <= 1'b1;
      wr_en    <= 1'b0;
      clr_done <= 1'b0;
      // ready stays low through the clr_done cycle
      if (clr_done) clr_pending <= 1'b0;
      if (req_fire && !in_range && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;

      case (state)
        S_IDLE, S_DRAIN: begin
          if (en) begin
            if (pend_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= pend_addr;
              wr_data <= pend_data;
            end
            pend_valid <= pop;
            if (pop) begin
              pend_addr <= fifo_addr[rd_ptr];
              pend_data <= fifo_data[rd_ptr];
            end
          end
          if ((state == S_IDLE) && clr_accept) begin
            state       <= S_DRAIN;
            clr_pending <= 1'b1;
            clr_fill    <= clr_color;
          end
          if ((state == S_DRAIN) && fifo_empty && !pend_valid) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end
        end
        S_CLEAR: begin
          if (en) begin
            wr_en    <= 1'b1;
            wr_addr  <= clr_addr;
            wr_data  <= clr_fill;
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == LAST_ADDR) state <= S_FIN;
          end
        end
        S_FIN: begin
          clr_done <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb/tb_fb_pixel_writer.sv - directed self-checking bench for fb_pixel_writer
module tb_fb_pixel_writer;
  localparam int H    = 640;
  localparam int V    = 32;
  localparam int AW   = 19;
  localparam int DW   = 4;
  localparam int NPIX = H * V;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [9:0]    req_x = '0;
  logic [8:0]    req_y = '0;
  logic [DW-1:0] req_color = '0;
  logic          clr_start = 1'b0;
  logic [DW-1:0] clr_color = '0;
  logic          vblank = 1'b1;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          clr_done;
  logic [7:0]    drop_cnt;

  fb_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color),
    .clr_start(clr_start), .clr_color(clr_color), .vblank(vblank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .clr_done(clr_done), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_cnt = 0;
  int ready_hi_clr = 0;
  bit watch_clr = 1'b0;
  logic [AW+DW-1:0] wq[$];
  int wcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // write log sampled mid-cycle; cyc-1 is the index of the edge that launched it
  always @(negedge clk) begin
    if (wr_en) begin
      wq.push_back({wr_addr, wr_data});
      wcyc.push_back(cyc - 1);
    end
    if (clr_done) done_cnt++;
    if (watch_clr && req_ready) ready_hi_clr++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send(input int x, input int y, input int c);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_x = 10'(x); req_y = 9'(y); req_color = 4'(c);
    for (int n = 0; n < 50 && !ok; n++) begin
      if (req_ready) begin
        @(posedge clk);
        acc_cyc = cyc;
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    check("accept", 32'(ok), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_clr_done"}, 32'(clr_done), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  initial begin
    int n, errs, base, rdy_low;

    // reset
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // single write: 2*640+3 = 1283
    wq.delete(); wcyc.delete();
    send(3, 2, 4'hA);
    repeat (5) @(negedge clk);
    check("single_cnt", 32'(wq.size()), 32'd1);
    check("single_word", 32'(wq[0]), 32'({19'd1283, 4'hA}));
    check("single_lat", 32'(wcyc[0] - acc_cyc), 32'd2);
    check("single_drop", 32'(drop_cnt), 32'd0);
    check("single_busy", 32'(busy), 32'd0);

    // out of range
    wq.delete(); wcyc.delete();
    send(640, 0, 1);
    send(0, 480, 1);
    repeat (5) @(negedge clk);
    check("oor_writes", 32'(wq.size()), 32'd0);
    check("oor_drop2", 32'(drop_cnt), 32'd2);
    for (int i = 0; i < 300; i++) send(1023, i % 500, 2);
    repeat (3) @(negedge clk);
    check("oor_sat", 32'(drop_cnt), 32'd255);
    check("oor_writes2", 32'(wq.size()), 32'd0);

    // back-to-back burst on row 0
    wq.delete(); wcyc.delete();
    rdy_low = 0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_x = 10'(i); req_y = 9'd0; req_color = 4'(i);
      if (!req_ready) rdy_low++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("burst_ready_low", 32'(rdy_low), 32'd0);
    check("burst_cnt", 32'(wq.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check("burst_word", 32'(wq[i]), 32'({19'(i), 4'(i)}));
    check("burst_span", 32'(wcyc[9] - wcyc[0]), 32'd9);

    // clear with simultaneous request (1,1) -> 641
    wq.delete(); wcyc.delete();
    base = done_cnt;
    @(negedge clk);
    check("clr_ready_before", 32'(req_ready), 32'd1);
    clr_start = 1'b1; clr_color = 4'h5;
    req_valid = 1'b1; req_x = 10'd1; req_y = 9'd1; req_color = 4'hF;
    @(posedge clk); #1;
    clr_start = 1'b0; req_valid = 1'b0; watch_clr = 1'b1;
    n = 0;
    while (!clr_done && n < NPIX + 100) begin
      @(negedge clk);
      n++;
    end
    check("clr_done_seen", 32'(clr_done), 32'd1);
    check("clr_ready_in_done", 32'(req_ready), 32'd0);
    check("clr_busy_in_done", 32'(busy), 32'd0);
    watch_clr = 1'b0;
    @(negedge clk);
    check("clr_ready_after", 32'(req_ready), 32'd1);
    check("clr_done_pulse", 32'(clr_done), 32'd0);
    check("clr_ready_hi", 32'(ready_hi_clr), 32'd0);
    check("clr_cnt", 32'(wq.size()), 32'(NPIX + 1));
    check("clr_first", 32'(wq[0]), 32'({19'd641, 4'hF}));
    errs = 0;
    for (int i = 0; i < NPIX; i++)
      if (wq[i + 1] !== {19'(i), 4'h5}) errs++;
    check("clr_words", 32'(errs), 32'd0);
    check("clr_done_once", 32'(done_cnt - base), 32'd1);

    // reset mid-clear at address 1000
    base = done_cnt;
    @(negedge clk);
    clr_start = 1'b1; clr_color = 4'h3;
    @(posedge clk); #1;
    clr_start = 1'b0;
    n = 0;
    while (!(wr_en && wr_addr == 19'd1000) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("mid_hit", 32'(wr_addr), 32'd1000);
    rst = 1'b1;
    #1;
    check_zero_outputs("mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_ready", 32'(req_ready), 32'd1);
    repeat (10) @(negedge clk);
    check("mid_no_done", 32'(done_cnt - base), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    wq.delete(); wcyc.delete();
    send(5, 0, 7);
    repeat (5) @(negedge clk);
    check("mid_post_write", 32'(wq[0]), 32'({19'd5, 4'h7}));

`ifdef FBW_VBLANK_ONLY_EN
    // writes held off until vblank
    wq.delete(); wcyc.delete();
    vblank = 1'b0;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_x = 10'(20 + i); req_y = 9'd1; req_color = 4'(i);
      if (req_ready) n++;
      @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("vb_accepted", 32'(n), 32'd4);
    check("vb_ready", 32'(req_ready), 32'd0);
    check("vb_no_write", 32'(wq.size()), 32'd0);
    vblank = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("vb_fifth_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("vb_cnt", 32'(wq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      check("vb_word", 32'(wq[i]), 32'({19'(660 + i), 4'(i)}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side companion to the VGA scan-out path. It accepts pixel write requests (x, y, colour) from the processor over a valid/ready handshake and converts coordinates to linear framebuffer addresses. It buffers requests in a 4-entry FIFO and drives the write port of the dual-port video RAM whose read port the VGA controller scans. It also performs a hardware full-screen clear/fill.

## Interface
- `H_RES`, 640: pixels per line.
- `V_RES`, 480: lines per frame.
- `ADDR_W`, 19: framebuffer address width; must satisfy 2^ADDR_W ≥ H_RES·V_RES.
- `DATA_W`, 4: bits per pixel, matching the VGA data input.
- `clk`  in  1: pixel clock, the same `vgaclk` domain as the processor.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  1: pixel write request valid.
- `req_ready`  out  1: request accepted when `req_valid && req_ready` at a rising edge.
- `req_x`  in  10: column.
- `req_y`  in  9: row.
- `req_color`  in  DATA_W: pixel value.
- `clr_start`  in  1: single-cycle pulse; fill the whole frame with `clr_color`.
- `clr_color`  in  DATA_W: fill value, sampled when `clr_start` is accepted.
- `vblank`  in  1: vertical blanking indicator from the VGA timing.
- `wr_en`  out  1: RAM write strobe.
- `wr_addr`  out  ADDR_W: RAM write address.
- `wr_data`  out  DATA_W: RAM write data.
- `busy`  out  1: high while the FIFO is non-empty, an output write is pending, or a clear is active.
- `clr_done`  out  1: one-cycle pulse after the last clear write.
- `drop_cnt`  out  8: saturating count of dropped out-of-range requests.

## Operation
- **Reset values:** every output is 0 and `req_ready` is 0 while `rst` is high. `req_ready` returns to 1 on the first cycle after reset deassertion. The FIFO is emptied, the FSM goes to IDLE, and `drop_cnt` is 0.
- **Address:** `addr = req_y*H_RES + req_x`, computed at full width and truncated to ADDR_W.
- **Range check:** a request with `req_x ≥ H_RES` or `req_y ≥ V_RES` is still accepted, but it is not pushed. `drop_cnt` increments and saturates at 255.
- **Ready rule:** `req_ready = !fifo_full && state==IDLE && !clr_pending`.
- **FSM states:**
  - IDLE: pops the FIFO into the output register, one entry per enabled cycle.
  - DRAIN: entered on an accepted `clr_start`. Keeps popping until the FIFO is empty and no output write is pending, then goes to CLEAR.
  - CLEAR: writes `clr_color` to addresses 0 .. H_RES·V_RES−1, one per enabled cycle. After the last write it pulses `clr_done` and returns to IDLE.
- **Clear acceptance:** `clr_start` is accepted only in IDLE and ignored otherwise. `clr_pending` blocks new requests from the acceptance cycle onward.
- **Simultaneous `clr_start` and request in IDLE:** the request is accepted and written before any clear write.
- **FIFO boundaries:**
  - With 4 entries, `req_ready` drops in the cycle the FIFO holds 4.
  - A push and a pop in the same cycle on a full FIFO are not permitted, because ready is already low.
  - A push and a pop in the same cycle on a non-full FIFO keeps the count unchanged.
- **Reset mid-clear:** the clear is aborted and `clr_done` does not pulse. RAM contents are whatever was already written.

## Timing
- **Write latency:** a request accepted at edge N with an empty FIFO and writes enabled produces `wr_en`=1 with its address and data during the cycle after edge N+2, which is 2-cycle latency.
- **Throughput:** one pixel per cycle sustained.
- `wr_en` is high for exactly one cycle per write. `wr_addr` and `wr_data` are registered outputs and are valid whenever `wr_en`=1.
- **Clear duration:** H_RES·V_RES consecutive enabled cycles, i.e. 307200 with defaults. `clr_done` is asserted the cycle after the final clear write.
- `busy` falls in the same cycle `clr_done` pulses, or in the cycle after the last FIFO write.

## Configuration
- **`FBW_VBLANK_ONLY_EN` defined:** FIFO pops and clear writes occur only in cycles where `vblank`=1.
  - When `vblank` is low, outputs hold with `wr_en`=0, the FIFO keeps accepting until full, and a clear pauses and resumes at the next address.
  - Latency becomes 2 cycles plus the wait for `vblank`.
- **Not defined:** `vblank` is ignored and every cycle is enabled.

## Test plan
- **Single write:** after reset, request (x=3, y=2, color=4'hA) → `wr_en` 2 cycles later with `wr_addr`=1283 and `wr_data`=4'hA; `drop_cnt`=0.
- **Out of range:** request (x=640, y=0) then (x=0, y=480) → no `wr_en` for either, `drop_cnt`=2. Next, 300 more out-of-range requests → `drop_cnt` stays at 255.
- **Back-to-back burst:** requests with x=0..9 and y=0 held valid every cycle → 10 consecutive `wr_en` with `wr_addr` 0..9 and `req_ready` never low.
- **Clear with simultaneous request:** `clr_start` (clr_color=4'h5) in the same cycle as request (1,1,4'hF):
  - address 641 is written first;
  - then addresses 0..307199 are written with 4'h5;
  - then `clr_done` pulses once;
  - `req_ready` stays low throughout and goes high the cycle after `clr_done`.
- **Reset mid-clear:** assert `rst` at clear address 1000 → all outputs are 0 immediately, no `clr_done`, and `req_ready`=1 one cycle after release.
- **With `FBW_VBLANK_ONLY_EN`:** `vblank`=0 and 5 requests → 4 accepted, `req_ready` low, no `wr_en`. Raise `vblank` → 4 writes in order, then the fifth request is accepted.
